// File: rtl/fb_video_mixer_if.sv
// Framebuffer FIFO head/pop handshake plus composited video outputs of the mixer.
interface fb_video_mixer_if;
  logic        iFB_START;
  logic [30:0] iFB_DATA;
  logic        iFB_DATA_VALID;
  logic        oFB_READY;
  logic [14:0] oPIXEL;
  logic        oDE;
  logic        oHS;
  logic        oVS;
  logic        oLOCKED;
  logic [15:0] oUNDERFLOW_CNT;

  modport master (
    output iFB_START, iFB_DATA, iFB_DATA_VALID,
    input  oFB_READY, oPIXEL, oDE, oHS, oVS, oLOCKED, oUNDERFLOW_CNT
  );

  modport slave (
    input  iFB_START, iFB_DATA, iFB_DATA_VALID,
    output oFB_READY, oPIXEL, oDE, oHS, oVS, oLOCKED, oUNDERFLOW_CNT
  );
endinterface

// File: rtl/fb_video_mixer.sv
// Framebuffer scan-out: pops camera/overlay word pairs, composites them to RGB555
// and emits HS/VS/DE timing, holding frame lock against the start flag.
module fb_video_mixer #(
  parameter int unsigned pH_ACTIVE = 640,
  parameter int unsigned pH_FP     = 16,
  parameter int unsigned pH_SYNC   = 96,
  parameter int unsigned pH_BP     = 48,
  parameter int unsigned pV_ACTIVE = 480,
  parameter int unsigned pV_FP     = 10,
  parameter int unsigned pV_SYNC   = 2,
  parameter int unsigned pV_BP     = 33
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  fb_video_mixer_if.slave   fb
);

  localparam int unsigned HTOT   = pH_ACTIVE + pH_FP + pH_SYNC + pH_BP;
  localparam int unsigned VTOT   = pV_ACTIVE + pV_FP + pV_SYNC + pV_BP;
  localparam int unsigned HW     = $clog2(HTOT);
  localparam int unsigned VW     = $clog2(VTOT);
  localparam int unsigned HS_BEG = pH_ACTIVE + pH_FP;
  localparam int unsigned HS_END = HS_BEG + pH_SYNC;
  localparam int unsigned VS_BEG = pV_ACTIVE + pV_FP;
  localparam int unsigned VS_END = VS_BEG + pV_SYNC;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [0:0]    state_q, state_d;
  logic [14:0]   pix_q, pix_d;
  logic          de_q, hs_q, vs_q;
  logic [15:0]   ucnt_q, ucnt_d;

  logic          h_wrap_c, v_wrap_c, active_c, at_org_c, at_end_c;
  logic          hsync_c, vsync_c, ready_c, uflow_c;
  logic [14:0]   mix_c;

  // Raster position decode
  always_comb begin
    h_wrap_c = (32'(h_q) == HTOT - 1);
    v_wrap_c = (32'(v_q) == VTOT - 1);
    active_c = (32'(h_q) < pH_ACTIVE) && (32'(v_q) < pV_ACTIVE);
    at_org_c = (h_q == '0) && (v_q == '0);
    at_end_c = h_wrap_c && v_wrap_c;
    hsync_c  = (32'(h_q) >= HS_BEG) && (32'(h_q) < HS_END);
    vsync_c  = (32'(v_q) >= VS_BEG) && (32'(v_q) < VS_END);
    h_d      = h_wrap_c ? '0 : h_q + HW'(1);
    v_d      = v_q;
    if (h_wrap_c) begin
      v_d = v_wrap_c ? '0 : v_q + VW'(1);
    end
    mix_c    = fb.iFB_DATA[30] ? fb.iFB_DATA[29:15] : fb.iFB_DATA[14:0];
  end

  // Lock FSM; in RUN a start flag is expected exactly at the frame origin
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    pix_d   = '0;
    uflow_c = 1'b0;
    case (state_q)
      ST_SYNC: begin
        ready_c = fb.iFB_DATA_VALID & ~fb.iFB_START;
        if (fb.iFB_DATA_VALID && fb.iFB_START && at_end_c) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (active_c) begin
          if (!fb.iFB_DATA_VALID) begin
            uflow_c = 1'b1;
            if (at_org_c) state_d = ST_SYNC;
          end else if (fb.iFB_START != at_org_c) begin
            state_d = ST_SYNC;
          end else begin
            ready_c = 1'b1;
            pix_d   = mix_c;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
    ucnt_d = (uflow_c && (ucnt_q != 16'hFFFF)) ? ucnt_q + 16'd1 : ucnt_q;
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      h_q     <= '0;
      v_q     <= '0;
      state_q <= ST_SYNC;
      pix_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      ucnt_q  <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      pix_q   <= pix_d;
      de_q    <= active_c;
      hs_q    <= ~hsync_c;
      vs_q    <= ~vsync_c;
      ucnt_q  <= ucnt_d;
    end
  end

  // Pop strobe is combinational; gated so nothing is consumed while reset is held
  assign fb.oFB_READY      = ready_c & iRESETn;
  assign fb.oPIXEL         = pix_q;
  assign fb.oDE            = de_q;
  assign fb.oHS            = hs_q;
  assign fb.oVS            = vs_q;
  assign fb.oLOCKED        = (state_q == ST_RUN);
  assign fb.oUNDERFLOW_CNT = ucnt_q;

endmodule

// File: tb/tb_fb_video_mixer.sv
// Directed bench for fb_video_mixer on a reduced 15x8 raster (8x4 active, 120 cycles/frame).
module tb_fb_video_mixer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fb_video_mixer_if fb ();

  fb_video_mixer #(
    .pH_ACTIVE(8), .pH_FP(2), .pH_SYNC(3), .pH_BP(2),
    .pV_ACTIVE(4), .pV_FP(1), .pV_SYNC(2), .pV_BP(1)
  ) dut (
    .iCLK   (clk),
    .iRESETn(rst_n),
    .fb     (fb)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] fifo[$];
  int          cyc = 0;
  logic [14:0] exp_pix = '0;
  int          pops[8], den[8], hsn[8], vsn[8], pixerr[8];

  logic        s_rdy, s_de, s_hs, s_vs, s_lock;
  logic [14:0] s_pix;
  logic [15:0] s_ucnt;
  logic [31:0] s_head;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Word i of a frame: even words opaque overlay, odd words camera
  function automatic logic [31:0] word(input int i, input logic st);
    logic [14:0] ovl, cam;
    ovl = 15'h7C00 ^ 15'(i);
    cam = 15'h001F ^ 15'((i >> 1) << 5);
    return {st, 1'((i % 2) == 0), ovl, cam};
  endfunction

  function automatic logic [14:0] mix(input logic [31:0] w);
    return w[30] ? w[29:15] : w[14:0];
  endfunction

  task automatic drive();
    logic        gap;
    logic [31:0] h;
    gap = (cyc >= 273) && (cyc <= 275);
    if (fifo.size() > 0 && !gap) begin
      h = fifo[0];
      fb.iFB_DATA_VALID = 1'b1;
      fb.iFB_START      = h[31];
      fb.iFB_DATA       = h[30:0];
    end else begin
      fb.iFB_DATA_VALID = 1'b0;
      fb.iFB_START      = 1'b0;
      fb.iFB_DATA       = '0;
    end
  endtask

  task automatic tick();
    int f;
    @(negedge clk);
    s_rdy  = fb.oFB_READY;
    s_pix  = fb.oPIXEL;
    s_de   = fb.oDE;
    s_hs   = fb.oHS;
    s_vs   = fb.oVS;
    s_lock = fb.oLOCKED;
    s_ucnt = fb.oUNDERFLOW_CNT;
    s_head = (fifo.size() > 0) ? fifo[0] : 32'h0;
    f = (cyc / 120) % 8;
    if (s_rdy) pops[f]++;
    if (cyc > 0) begin
      f = ((cyc - 1) / 120) % 8;
      if (s_de)  den[f]++;
      if (!s_hs) hsn[f]++;
      if (!s_vs) vsn[f]++;
      if (s_pix !== exp_pix) pixerr[f]++;
    end
    exp_pix = (s_rdy && s_lock) ? mix(s_head) : 15'h0;
    @(posedge clk);
    #1;
    if (s_rdy && fifo.size() > 0) void'(fifo.pop_front());
    cyc++;
    drive();
  endtask

  task automatic go(input int c);
    while (cyc <= c) tick();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_pix"},   32'(fb.oPIXEL), 32'h0);
    chk({pfx, "_de"},    32'(fb.oDE), 32'h0);
    chk({pfx, "_hs"},    32'(fb.oHS), 32'h1);
    chk({pfx, "_vs"},    32'(fb.oVS), 32'h1);
    chk({pfx, "_lock"},  32'(fb.oLOCKED), 32'h0);
    chk({pfx, "_ucnt"},  32'(fb.oUNDERFLOW_CNT), 32'h0);
    chk({pfx, "_ready"}, 32'(fb.oFB_READY), 32'h0);
  endtask

  initial begin
    int tot;
    fb.iFB_START = 1'b0; fb.iFB_DATA = '0; fb.iFB_DATA_VALID = 1'b0;
    for (int k = 0; k < 5; k++) fifo.push_back(word(100 + k, 1'b0));
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 32; i++)
        fifo.push_back(word(i, 1'((i == 0) || (f == 3 && i == 13))));
    drive();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Stale drain and lock on the first frame
    go(119); chk("lock_before_origin", 32'(s_lock), 32'h0);
    go(120); chk("lock_at_origin",     32'(s_lock), 32'h1);
    go(121); chk("pix_opaque",         32'(s_pix),  32'h7C00);
    go(122); chk("pix_camera",         32'(s_pix),  32'h001F);
    go(241);
    chk("pops_sync_stale", 32'(pops[0]), 32'd5);
    chk("pops_frame_a",    32'(pops[1]), 32'd32);
    chk("de_frame_a",      32'(den[1]),  32'd32);
    chk("hs_low_frame_a",  32'(hsn[1]),  32'd24);
    chk("vs_low_frame_a",  32'(vsn[1]),  32'd30);

    // Three-pixel underflow on line 2, then failed start check and relock
    go(276); chk("pix_underflow", 32'(s_pix), 32'h0);
    go(300); chk("ucnt_3", 32'(s_ucnt), 32'd3);
    go(360); chk("lock_before_fail", 32'(s_lock), 32'h1);
    go(361); chk("lock_dropped",     32'(s_lock), 32'h0);
    go(480); chk("relock_after_uf",  32'(s_lock), 32'h1);
    chk("pops_frame_b",    32'(pops[2]), 32'd29);
    chk("pops_resync",     32'(pops[3]), 32'd3);

    // Unexpected start word at (5,1)
    go(620); chk("lock_before_inject", 32'(s_lock), 32'h1);
    go(621); chk("lock_inject_drop",   32'(s_lock), 32'h0);
    go(720); chk("relock_after_inj",   32'(s_lock), 32'h1);
    chk("pops_frame_c", 32'(pops[4]), 32'd32);
    chk("pops_frame_d", 32'(pops[5]), 32'd13);
    tot = 0;
    for (int f = 0; f < 6; f++) tot += pixerr[f];
    chk("pix_stream_errors", 32'(tot), 32'd0);

    // Mid-line reset
    go(740);
    chk("pre_rst_de",   32'(s_de),   32'h1);
    chk("pre_rst_ucnt", 32'(s_ucnt), 32'd3);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1 chk("midrst_hold_ready", 32'(fb.oFB_READY), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    exp_pix = '0;
    drive();
    go(0);  chk("post_rst_de0",  32'(s_de), 32'h0);
    go(1);  chk("post_rst_de1",  32'(s_de), 32'h1);
    go(10); chk("post_rst_hs10", 32'(s_hs), 32'h1);
    go(11); chk("post_rst_hs11", 32'(s_hs), 32'h0);
    go(13); chk("post_rst_hs13", 32'(s_hs), 32'h0);
    go(14); chk("post_rst_hs14", 32'(s_hs), 32'h1);
    go(75); chk("post_rst_vs75", 32'(s_vs), 32'h1);
    go(76); chk("post_rst_vs76", 32'(s_vs), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
